// File: rtl/pulse_train_generator.sv
// Pulse-train output channel: each accepted START drives N pulses of H high / L low cycles on sig_out, then reports the outcome.
// Latency: sig_out rises one cycle after an accepted START; a report is written one cycle after its deciding cycle (two if deferred).
// Backpressure: none; commands are strobes, a START while busy is rejected, and one colliding rejection is held for the next cycle.
module pulse_train_generator #(
    parameter int DATA_WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [63:0]  cmd_in,
    input  logic         valid,
    input  logic [63:0]  counter,
    output logic         sig_out,
    output logic         busy,
    output logic         write,
    output logic [127:0] report_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    typedef struct packed {
        logic [63:0] ts;
        logic [15:0] rsvd_hi;
        logic [15:0] emitted;
        logic [29:0] rsvd_lo;
        logic [1:0]  status;
    } report_t;

    localparam logic [1:0] OP_START       = 2'b01;
    localparam logic [1:0] OP_STOP        = 2'b10;
    localparam logic [1:0] STAT_DONE      = 2'b00;
    localparam logic [1:0] STAT_STOPPED   = 2'b01;
    localparam logic [1:0] STAT_REJECTED  = 2'b10;
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                state;
    logic [DATA_WIDTH-1:0] h_len;
    logic [DATA_WIDTH-1:0] l_len;
    logic [DATA_WIDTH-1:0] phase_cnt;
    logic [DATA_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0] emitted;

    logic                  pend_vld;
    logic [63:0]           pend_ts;
    report_t               report_q;

    logic [DATA_WIDTH-1:0] fld_n;
    logic [DATA_WIDTH-1:0] fld_h;
    logic [DATA_WIDTH-1:0] fld_l;
    logic                  is_start;
    logic                  is_stop;
    logic                  fields_ok;
    logic                  last_low;
    logic                  accept;
    logic                  reject;
    logic                  do_stop;
    logic                  finish;
    logic                  unused_cmd;

    function automatic report_t make_report(input logic [63:0]           ts,
                                            input logic [DATA_WIDTH-1:0] em,
                                            input logic [1:0]            status);
        report_t r;
        r         = '0;
        r.ts      = ts;
        r.emitted = 16'(em);
        r.status  = status;
        return r;
    endfunction

    // Command decode and the per-cycle decisions shared by the FSM and the report path
    always_comb begin
        fld_n     = cmd_in[32 +: DATA_WIDTH];
        fld_h     = cmd_in[16 +: DATA_WIDTH];
        fld_l     = cmd_in[0  +: DATA_WIDTH];
        is_start  = valid && (cmd_in[63:62] == OP_START);
        is_stop   = valid && (cmd_in[63:62] == OP_STOP);
        fields_ok = (fld_n != '0) && (fld_h != '0) && (fld_l != '0);
        // The last LOW cycle of the last pulse: DONE is decided here and beats any STOP
        last_low  = (state == ST_LOW) && (phase_cnt == ONE) && (remaining == ONE);
        accept    = is_start && (state == ST_IDLE) && fields_ok;
        reject    = is_start && !accept;
        do_stop   = is_stop && (state != ST_IDLE) && !last_low;
        finish    = last_low || do_stop;
    end

    // Opcode gap bits and any field bits above DATA_WIDTH carry no meaning
    assign unused_cmd = ^cmd_in;

    // Pulse FSM: phase_cnt counts down the cycles left in the current HIGH or LOW phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sig_out   <= 1'b0;
            busy      <= 1'b0;
            h_len     <= '0;
            l_len     <= '0;
            phase_cnt <= '0;
            remaining <= '0;
            emitted   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_HIGH;
                        sig_out   <= 1'b1;
                        busy      <= 1'b1;
                        h_len     <= fld_h;
                        l_len     <= fld_l;
                        phase_cnt <= fld_h;
                        remaining <= fld_n;
                        emitted   <= ONE;
                    end
                end
                ST_HIGH: begin
                    if (do_stop) begin
                        state   <= ST_IDLE;
                        sig_out <= 1'b0;
                        busy    <= 1'b0;
                    end else if (phase_cnt == ONE) begin
                        state     <= ST_LOW;
                        sig_out   <= 1'b0;
                        phase_cnt <= l_len;
                    end else begin
                        phase_cnt <= phase_cnt - ONE;
                    end
                end
                ST_LOW: begin
                    if (do_stop) begin
                        state   <= ST_IDLE;
                        sig_out <= 1'b0;
                        busy    <= 1'b0;
                    end else if (phase_cnt == ONE) begin
                        if (remaining != ONE) begin
                            state     <= ST_HIGH;
                            sig_out   <= 1'b1;
                            phase_cnt <= h_len;
                            remaining <= remaining - ONE;
                            emitted   <= emitted + ONE;
                        end else begin
                            state   <= ST_IDLE;
                            sig_out <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - ONE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    sig_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Report path: DONE/STOPPED first, a colliding rejection waits one cycle, a second one is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write    <= 1'b0;
            report_q <= '0;
            pend_vld <= 1'b0;
            pend_ts  <= '0;
        end else begin
            write <= 1'b0;
            if (finish) begin
                write    <= 1'b1;
                report_q <= make_report(counter, emitted, last_low ? STAT_DONE : STAT_STOPPED);
                if (reject && !pend_vld) begin
                    pend_vld <= 1'b1;
                    pend_ts  <= counter;
                end
            end else if (pend_vld) begin
                write    <= 1'b1;
                report_q <= make_report(pend_ts, '0, STAT_REJECTED);
                pend_vld <= 1'b0;
            end else if (reject) begin
                write    <= 1'b1;
                report_q <= make_report(counter, '0, STAT_REJECTED);
            end
        end
    end

    assign report_out = report_q;

endmodule
